// File: rtl/fp_sign_pipe_if.sv
// Op/result handshake bundle for the FP sign-injection unit.
// The master side issues ops and consumes results; the slave side is the unit.
interface fp_sign_pipe_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 6
);
  logic                 flush;
  logic                 inValid;
  logic                 inReady;
  logic [1:0]           inCommand;
  logic                 inDouble;
  logic [WIDTH-1:0]     inSrc1;
  logic [WIDTH-1:0]     inSrc2;
  logic [TAG_WIDTH-1:0] inTag;
  logic                 outValid;
  logic                 outReady;
  logic [WIDTH-1:0]     outResult;
  logic [TAG_WIDTH-1:0] outTag;
  logic                 outIllegal;

  modport master (
    output flush, inValid, inCommand, inDouble, inSrc1, inSrc2, inTag, outReady,
    input  inReady, outValid, outResult, outTag, outIllegal
  );

  modport slave (
    input  flush, inValid, inCommand, inDouble, inSrc1, inSrc2, inTag, outReady,
    output inReady, outValid, outResult, outTag, outIllegal
  );
endinterface

// File: rtl/fp_sign_pipe.sv
// Pipelined FSGNJ/FSGNJN/FSGNJX unit with issue tag, flush and valid/ready flow control.
// The result is formed ahead of stage 0; later stages only store and forward.
module fp_sign_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned TAG_WIDTH = 6
) (
  input logic           clk,
  input logic           rst,
  fp_sign_pipe_if.slave bus
);

  localparam logic [1:0]  CmdSgnj  = 2'd0;
  localparam logic [1:0]  CmdSgnjn = 2'd1;
  localparam logic [1:0]  CmdSgnjx = 2'd2;
  localparam logic [1:0]  CmdRsvd  = 2'd3;
  localparam logic [31:0] CanonNan = 32'h7FC0_0000;

  function automatic logic sign_sel(logic [1:0] cmd, logic s1, logic s2);
    logic s;
    case (cmd)
      CmdSgnj:  s = s2;
      CmdSgnjn: s = ~s2;
      CmdSgnjx: s = s1 ^ s2;
      default:  s = 1'b0;
    endcase
    return s;
  endfunction

  logic             illegal;
  logic [31:0]      sp_src1;
  logic             sp_s2;
  logic             sgn_sp;
  logic             sgn_dp;
  logic [WIDTH-1:0] res_sp;
  logic [WIDTH-1:0] res_dp;
  logic [WIDTH-1:0] result;
  logic             unused_src2;

  // Only the sign of src2 matters; its magnitude bits are never consumed.
  assign unused_src2 = ^bus.inSrc2[30:0];

  if (WIDTH == 64) begin : g_box
    // Improperly NaN-boxed single operands read as the canonical quiet NaN.
    assign sp_src1 = (&bus.inSrc1[WIDTH-1:32]) ? bus.inSrc1[31:0] : CanonNan;
    assign sp_s2   = (&bus.inSrc2[WIDTH-1:32]) ? bus.inSrc2[31]   : CanonNan[31];
    assign res_sp  = {{(WIDTH - 32){1'b1}}, sgn_sp, sp_src1[30:0]};
  end else begin : g_nobox
    assign sp_src1 = bus.inSrc1[31:0];
    assign sp_s2   = bus.inSrc2[31];
    assign res_sp  = {sgn_sp, sp_src1[30:0]};
  end

  assign sgn_sp  = sign_sel(bus.inCommand, sp_src1[31], sp_s2);
  assign sgn_dp  = sign_sel(bus.inCommand, bus.inSrc1[WIDTH-1], bus.inSrc2[WIDTH-1]);
  assign res_dp  = {sgn_dp, bus.inSrc1[WIDTH-2:0]};
  assign illegal = (bus.inCommand == CmdRsvd) || (bus.inDouble && (WIDTH == 32));

  always_comb begin
    result = res_sp;
    if (illegal) begin
      result = '0;
    end else if (bus.inDouble) begin
      result = res_dp;
    end
  end

  logic [STAGES-1:0]    valid_q;
  logic [STAGES-1:0]    illegal_q;
  logic [WIDTH-1:0]     result_q [STAGES];
  logic [TAG_WIDTH-1:0] tag_q    [STAGES];

  logic [STAGES:0]      adv;
  logic                 in_fire;
  logic [STAGES-1:0]    src_valid;
  logic [STAGES-1:0]    src_illegal;
  logic [WIDTH-1:0]     src_result [STAGES];
  logic [TAG_WIDTH-1:0] src_tag    [STAGES];

  // A stage may load when empty or when its successor is taking its contents.
  always_comb begin
    adv         = '0;
    adv[STAGES] = bus.outReady;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | adv[i+1];
    end
  end

  assign in_fire = bus.inValid & bus.inReady;

  always_comb begin
    src_valid[0]   = in_fire;
    src_illegal[0] = illegal;
    src_result[0]  = result;
    src_tag[0]     = bus.inTag;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i]   = valid_q[i-1];
      src_illegal[i] = illegal_q[i-1];
      src_result[i]  = result_q[i-1];
      src_tag[i]     = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      illegal_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        result_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (bus.flush) begin
          valid_q[i] <= 1'b0;
        end else if (adv[i]) begin
          valid_q[i] <= src_valid[i];
        end
        if (adv[i] && src_valid[i]) begin
          illegal_q[i] <= src_illegal[i];
          result_q[i]  <= src_result[i];
          tag_q[i]     <= src_tag[i];
        end
      end
    end
  end

  assign bus.inReady    = adv[0];
  assign bus.outValid   = valid_q[STAGES-1];
  assign bus.outResult  = result_q[STAGES-1];
  assign bus.outTag     = tag_q[STAGES-1];
  assign bus.outIllegal = illegal_q[STAGES-1];

endmodule

// File: tb/tb_fp_sign_pipe.sv
// Bench for fp_sign_pipe: a 32-bit/2-stage and a 64-bit/3-stage instance, directed cases
// followed by random traffic scored against a behavioural sign-injection model.
module tb_fp_sign_pipe;

  typedef struct {
    logic [63:0] res;
    logic        ill;
    logic [5:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q32[$];
  exp_t q64[$];
  logic        st32 = 1'b0;
  logic        st64 = 1'b0;
  logic [63:0] hold_res32, hold_res64;
  logic [5:0]  hold_tag32, hold_tag64;

  fp_sign_pipe_if #(.WIDTH(32), .TAG_WIDTH(6)) b32 ();
  fp_sign_pipe_if #(.WIDTH(64), .TAG_WIDTH(6)) b64 ();

  fp_sign_pipe #(.WIDTH(32), .STAGES(2), .TAG_WIDTH(6)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  fp_sign_pipe #(.WIDTH(64), .STAGES(3), .TAG_WIDTH(6)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  always #5 clk = ~clk;

  // Sign injection from first principles: sign chosen by rule, magnitude = src1 mod 2^(n-1).
  function automatic exp_t model(int w, logic [1:0] cmd, logic dbl, logic [63:0] a,
                                 logic [63:0] b, logic [5:0] tag);
    exp_t e;
    int   n;
    logic sa, sb, s;
    e.tag = tag;
    e.ill = (cmd == 2'd3) || (dbl && w == 32);
    e.res = '0;
    if (!e.ill) begin
      n = dbl ? 64 : 32;
      if (!dbl && w == 64) begin
        if ((a >> 32) != 64'hFFFF_FFFF) a = 64'h7FC0_0000;
        if ((b >> 32) != 64'hFFFF_FFFF) b = 64'h7FC0_0000;
      end
      sa = a[n-1];
      sb = b[n-1];
      if (cmd == 2'd0) s = sb;
      else if (cmd == 2'd1) s = !sb;
      else s = sa ^ sb;
      e.res = (a & ((64'd1 << (n - 1)) - 64'd1)) + (s ? (64'd1 << (n - 1)) : 64'd0);
      if (!dbl && w == 64) e.res = e.res + 64'hFFFF_FFFF_0000_0000;
    end
    return e;
  endfunction

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive32(logic v, logic [1:0] cmd, logic dbl, logic [31:0] a, logic [31:0] b,
                         logic [5:0] tag);
    b32.inValid = v; b32.inCommand = cmd; b32.inDouble = dbl;
    b32.inSrc1 = a; b32.inSrc2 = b; b32.inTag = tag;
  endtask

  task automatic drive64(logic v, logic [1:0] cmd, logic dbl, logic [63:0] a, logic [63:0] b,
                         logic [5:0] tag);
    b64.inValid = v; b64.inCommand = cmd; b64.inDouble = dbl;
    b64.inSrc1 = a; b64.inSrc2 = b; b64.inTag = tag;
  endtask

  task automatic idle();
    b32.inValid = 1'b0; b32.flush = 1'b0;
    b64.inValid = 1'b0; b64.flush = 1'b0;
  endtask

  // One clock: sample just after the inputs settle, score both instances, then advance.
  task automatic tick();
    exp_t e;
    #2;
    if (st32) begin
      check("d32 hold valid", 64'(b32.outValid), 64'd1);
      check("d32 hold result", 64'(b32.outResult), hold_res32);
      check("d32 hold tag", 64'(b32.outTag), 64'(hold_tag32));
    end
    if (st64) begin
      check("d64 hold valid", 64'(b64.outValid), 64'd1);
      check("d64 hold result", b64.outResult, hold_res64);
      check("d64 hold tag", 64'(b64.outTag), 64'(hold_tag64));
    end
    if (b32.outValid && b32.outReady) begin
      check("d32 expected an op", 64'(q32.size() > 0), 64'd1);
      if (q32.size() > 0) begin
        e = q32.pop_front();
        check("d32 result", 64'(b32.outResult), e.res);
        check("d32 illegal", 64'(b32.outIllegal), 64'(e.ill));
        check("d32 tag", 64'(b32.outTag), 64'(e.tag));
      end
    end
    if (b64.outValid && b64.outReady) begin
      check("d64 expected an op", 64'(q64.size() > 0), 64'd1);
      if (q64.size() > 0) begin
        e = q64.pop_front();
        check("d64 result", b64.outResult, e.res);
        check("d64 illegal", 64'(b64.outIllegal), 64'(e.ill));
        check("d64 tag", 64'(b64.outTag), 64'(e.tag));
      end
    end
    st32 = b32.outValid && !b32.outReady && !b32.flush;
    st64 = b64.outValid && !b64.outReady && !b64.flush;
    hold_res32 = 64'(b32.outResult); hold_tag32 = b32.outTag;
    hold_res64 = b64.outResult;      hold_tag64 = b64.outTag;
    if (b32.flush) q32.delete();
    else if (b32.inValid && b32.inReady)
      q32.push_back(model(32, b32.inCommand, b32.inDouble, 64'(b32.inSrc1), 64'(b32.inSrc2),
                          b32.inTag));
    if (b64.flush) q64.delete();
    else if (b64.inValid && b64.inReady)
      q64.push_back(model(64, b64.inCommand, b64.inDouble, b64.inSrc1, b64.inSrc2, b64.inTag));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single op into an empty pipe; result must appear exactly STAGES edges after transfer.
  task automatic one_op(bit wide, logic [1:0] cmd, logic dbl, logic [63:0] a, logic [63:0] b,
                        logic [5:0] tag, logic [63:0] exp_res, logic exp_ill, string name);
    int stages = wide ? 3 : 2;
    if (wide) drive64(1'b1, cmd, dbl, a, b, tag);
    else drive32(1'b1, cmd, dbl, a[31:0], b[31:0], tag);
    tick();
    idle();
    for (int i = 1; i < stages; i++) begin
      check({name, " early"}, wide ? 64'(b64.outValid) : 64'(b32.outValid), 64'd0);
      tick();
    end
    #1;
    check({name, " valid"}, wide ? 64'(b64.outValid) : 64'(b32.outValid), 64'd1);
    check({name, " result"}, wide ? b64.outResult : 64'(b32.outResult), exp_res);
    check({name, " illegal"}, wide ? 64'(b64.outIllegal) : 64'(b32.outIllegal), 64'(exp_ill));
    check({name, " tag"}, wide ? 64'(b64.outTag) : 64'(b32.outTag), 64'(tag));
    tick();
  endtask

  initial begin
    logic [31:0] ha, hb;
    idle();
    drive32(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 6'd0);
    drive64(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 6'd0);
    b32.outReady = 1'b1; b64.outReady = 1'b1;

    // Reset state
    #3;
    check("rst d32 outValid", 64'(b32.outValid), 64'd0);
    check("rst d32 outResult", 64'(b32.outResult), 64'd0);
    check("rst d32 outTag", 64'(b32.outTag), 64'd0);
    check("rst d32 outIllegal", 64'(b32.outIllegal), 64'd0);
    check("rst d64 outValid", 64'(b64.outValid), 64'd0);
    check("rst d64 outResult", b64.outResult, 64'd0);
    check("rst d64 outIllegal", 64'(b64.outIllegal), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst d32 inReady", 64'(b32.inReady), 64'd1);
    check("rst d64 inReady", 64'(b64.inReady), 64'd1);

    // Directed single ops
    one_op(1'b0, 2'd1, 1'b0, 64'h3F80_0000, 64'h0, 6'd5, 64'hBF80_0000, 1'b0, "sgnjn32");
    one_op(1'b1, 2'd2, 1'b1, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd7,
           64'h4000_0000_0000_0000, 1'b0, "sgnjx64");
    one_op(1'b1, 2'd0, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_8000_0000, 6'd8,
           64'hFFFF_FFFF_FFC0_0000, 1'b0, "unboxed");
    one_op(1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_8000_0000, 6'd9,
           64'hFFFF_FFFF_BF80_0000, 1'b0, "boxed");
    one_op(1'b1, 2'd3, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 6'd3,
           64'h0, 1'b1, "rsvd64");
    one_op(1'b0, 2'd0, 1'b1, 64'h4049_0FDB, 64'h8000_0000, 6'd4, 64'h0, 1'b1, "dbl32");

    // Backpressure on the 3-stage instance
    b64.outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive64(1'b1, 2'd0, 1'b1, {32'h4000_0000, 32'(k)}, 64'h8000_0000_0000_0000, 6'(k));
      #1 check("bp accept", 64'(b64.inReady), 64'd1);
      tick();
    end
    drive64(1'b1, 2'd0, 1'b1, {32'h4000_0000, 32'd3}, 64'h8000_0000_0000_0000, 6'd3);
    #1 check("bp full", 64'(b64.inReady), 64'd0);
    tick();
    check("bp stalled valid", 64'(b64.outValid), 64'd1);
    b64.outReady = 1'b1;
    #1 check("bp no bubble", 64'(b64.inReady), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1)
        drive64(1'b1, 2'd0, 1'b1, {32'h4000_0000, 32'd4}, 64'h8000_0000_0000_0000, 6'd4);
      else if (k >= 2) b64.inValid = 1'b0;
      #1;
      check("bp stream valid", 64'(b64.outValid), 64'd1);
      check("bp stream tag", 64'(b64.outTag), 64'(k));
      tick();
    end
    check("bp drained", 64'(b64.outValid), 64'd0);
    check("bp none lost", 64'(q64.size()), 64'd0);

    // Flush a full 2-stage pipe
    b32.outReady = 1'b0;
    drive32(1'b1, 2'd0, 1'b0, 32'h3F80_0000, 32'h8000_0000, 6'd10); tick();
    drive32(1'b1, 2'd1, 1'b0, 32'h3F80_0000, 32'h8000_0000, 6'd11); tick();
    check("flush full before", 64'(b32.outValid), 64'd1);
    drive32(1'b1, 2'd2, 1'b0, 32'h3F80_0000, 32'h8000_0000, 6'd12);
    b32.flush = 1'b1;
    tick();
    idle();
    b32.outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check("flush full quiet", 64'(b32.outValid), 64'd0);
      tick();
    end
    // Flush together with an input that does transfer
    drive32(1'b1, 2'd0, 1'b0, 32'h1, 32'h8000_0000, 6'd13); tick();
    drive32(1'b1, 2'd0, 1'b0, 32'h2, 32'h8000_0000, 6'd14);
    b32.flush = 1'b1;
    #1 check("flush inReady", 64'(b32.inReady), 64'd1);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1 check("flush input quiet", 64'(b32.outValid), 64'd0);
      tick();
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drive32($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
              $urandom, $urandom, 6'($urandom));
      b32.outReady = $urandom_range(0, 3) != 0;
      b32.flush    = $urandom_range(0, 39) == 0;
      ha = $urandom_range(0, 1) != 0 ? 32'hFFFF_FFFF : $urandom;
      hb = $urandom_range(0, 1) != 0 ? 32'hFFFF_FFFF : $urandom;
      drive64($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom),
              {ha, 32'($urandom)}, {hb, 32'($urandom)}, 6'($urandom));
      b64.outReady = $urandom_range(0, 3) != 0;
      b64.flush    = $urandom_range(0, 39) == 0;
      tick();
    end
    idle();
    b32.outReady = 1'b1; b64.outReady = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("rand d32 drained", 64'(q32.size()), 64'd0);
    check("rand d64 drained", 64'(q64.size()), 64'd0);

    // Asynchronous reset with the 3-stage pipe full
    b64.outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive64(1'b1, 2'd1, 1'b1, 64'h1, 64'h0, 6'(20 + k));
      tick();
    end
    idle();
    #1 check("arst pre valid", 64'(b64.outValid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst outValid", 64'(b64.outValid), 64'd0);
    check("arst outResult", b64.outResult, 64'd0);
    check("arst outTag", 64'(b64.outTag), 64'd0);
    q32.delete(); q64.delete();
    st32 = 1'b0; st64 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    b64.outReady = 1'b1;
    #1;
    check("arst d64 inReady", 64'(b64.inReady), 64'd1);
    check("arst d32 inReady", 64'(b32.inReady), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("arst nothing left", 64'(b64.outValid), 64'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_sign_pipe.md
Name: fp_sign_pipe

Overview:
- Pipelined, parametrised FP sign-injection unit: FSGNJ / FSGNJN / FSGNJX for single precision, and for double precision when WIDTH=64.
- Sits in the FP execute cluster beside the other FP functional units.
- Accepts ops over a valid/ready handshake, carries an issue tag, supports pipeline flush.
- WIDTH=64 adds NaN-box checking on single-precision inputs and NaN-boxing on single-precision results.

Parameters:
- WIDTH, 32, datapath width; legal values 32 or 64.
- STAGES, 2, number of register stages; 1..4.
- TAG_WIDTH, 6, width of the issue tag carried alongside each op.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- flush  input  1  synchronous kill of every in-flight op.
- inValid  input  1  op presented.
- inReady  output  1  unit can accept an op this cycle.
- inCommand  input  2  0=Sgnj, 1=Sgnjn, 2=Sgnjx, 3=reserved.
- inDouble  input  1  1=double-precision op; must be 0 when WIDTH=32.
- inSrc1  input  WIDTH  magnitude/exponent source.
- inSrc2  input  WIDTH  sign source.
- inTag  input  TAG_WIDTH  issue tag.
- outValid  output  1  result available.
- outReady  input  1  consumer accepts the result.
- outResult  output  WIDTH  result.
- outTag  output  TAG_WIDTH  tag of the op producing outResult.
- outIllegal  output  1  op was reserved command, or inDouble=1 with WIDTH=32.

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage valid bits cleared; outValid=0.
  - outResult, outTag and outIllegal are 0.
  - inReady=1 as soon as rst returns high.
  - An op in flight when reset asserts is lost.
- Transfers:
  - Input transfer occurs when inValid&inReady.
  - Output transfer occurs when outValid&outReady.
- Pipeline:
  - STAGES registers, each holding valid, command result, tag and illegal flag.
  - Result is computed combinationally before stage 0; later stages are pure storage.
  - Stage i loads when it is empty or stage i+1 (or the output, for the last stage) is transferring.
  - Load occurs from stage i-1, or from the input for stage 0.
  - Stage i clears its valid when its contents move on and nothing enters.
- inReady = ~valid[0] | advance[0]. This is combinational from outReady; there is no extra cycle of ready latency.
- Latency:
  - Exactly STAGES cycles from input transfer to outValid when outReady is held 1.
  - Throughput is 1 op/cycle; full occupancy is STAGES ops.
- Backpressure:
  - With outReady=0, outputs hold stable.
  - Ops compress into empty stages until all are full, then inReady=0.
  - No op is dropped or duplicated.
- Single-precision operand handling:
  - S = bit 31, M = bits 30:0 of the low word.
  - WIDTH=64, inDouble=0: if the upper 32 bits of a source are not all ones, that source is replaced by 0x7FC00000 before use.
  - WIDTH=64, inDouble=0: the result's upper 32 bits are forced to 0xFFFFFFFF.
- Double-precision operand handling: S = bit 63, M = bits 62:0.
- Sign selection:
  - Sgnj: S2.
  - Sgnjn: ~S2.
  - Sgnjx: S1^S2.
  - The result takes the magnitude of src1.
- Reserved command, or inDouble=1 with WIDTH=32: outResult=0, outIllegal=1; the op still flows through and consumes a slot.
- Flush:
  - flush=1 clears all stage valid bits at the next edge.
  - An input transfer in the same cycle as flush is also discarded.
  - outValid=0 the cycle after flush.
  - inReady is unaffected during the flush cycle.
- Simultaneous full + outReady=1 + inValid=1: the pipeline advances and accepts the new op in the same cycle (no bubble).

Test Plan:
- WIDTH=32, STAGES=2, Sgnjn, src1=0x3F800000, src2=0x00000000, outReady=1 -> outValid exactly 2 cycles after transfer, outResult=0xBF800000, tag echoed.
- WIDTH=64, Sgnjx, inDouble=1, src1=0xC000000000000000, src2=0x8000000000000000 -> outResult=0x4000000000000000.
- WIDTH=64, Sgnj, inDouble=0:
  - src1=0x00000000_3F800000 (not boxed), src2=0xFFFFFFFF_80000000 -> outResult=0xFFFFFFFF_FFC00000.
  - Boxed src1=0xFFFFFFFF_3F800000 with the same src2 -> 0xFFFFFFFF_BF800000.
- STAGES=3, outReady=0 with 5 back-to-back ops -> inReady falls after 3 accepted; raise outReady -> results emerge in order, tags 0..4, one per cycle, none lost.
- Fill the pipe with 2 ops, assert flush together with a new input -> outValid=0 next cycle; no result for any of the 3 ops ever appears.
- inCommand=3, and separately inDouble=1 with WIDTH=32 -> outIllegal=1, outResult=0; rst pulsed low mid-stream -> outValid drops immediately (asynchronously), inReady=1 after release.
